// File: rtl/ethernet_crc32.sv
// rtl/ethernet_crc32.sv - IEEE 802.3 CRC-32 over a byte stream, one byte per accepted transfer
// Emits a one-cycle result strobe with the finished CRC and a saturating byte count.
module ethernet_crc32 #(
  parameter int BYTE_COUNT_WIDTH = 11
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [7:0]                  checksum_data,
  input  logic                        checksum_data_valid,
  input  logic                        checksum_data_last,
  output logic                        checksum_enable,
  output logic [31:0]                 checksum_result,
  output logic                        checksum_result_enable,
  output logic [BYTE_COUNT_WIDTH-1:0] checksum_byte_count
);

  localparam logic [31:0] POLY     = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

  typedef enum logic [1:0] {IDLE, ACCUMULATE, RESULT} state_t;

  state_t                      state_q, state_d;
  logic [31:0]                 crc_q, crc_d;
  logic [31:0]                 result_q, result_d;
  logic [BYTE_COUNT_WIDTH-1:0] count_q, count_d;
  logic [BYTE_COUNT_WIDTH-1:0] bytes_q, bytes_d;
  logic                        in_reset_q;
  logic                        accept;
  logic [31:0]                 crc_step;
  logic [BYTE_COUNT_WIDTH-1:0] count_inc;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Ready comes only from flops so the upstream parser never sees a comb loop.
  assign checksum_enable        = !in_reset_q && (state_q != RESULT);
  assign checksum_result        = result_q;
  assign checksum_result_enable = (state_q == RESULT);
  assign checksum_byte_count    = bytes_q;

  assign accept    = checksum_data_valid && checksum_enable;
  assign crc_step  = crc32_byte(crc_q, checksum_data);
  assign count_inc = (&count_q) ? count_q : count_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    crc_d    = crc_q;
    count_d  = count_q;
    result_d = result_q;
    bytes_d  = bytes_q;
    case (state_q)
      IDLE, ACCUMULATE: begin
        if (accept) begin
          if (checksum_data_last) begin
            result_d = ~crc_step;
            bytes_d  = count_inc;
            crc_d    = CRC_INIT;
            count_d  = '0;
            state_d  = RESULT;
          end else begin
            crc_d    = crc_step;
            count_d  = count_inc;
            state_d  = ACCUMULATE;
          end
        end
      end
      RESULT: begin
        crc_d   = CRC_INIT;
        count_d = '0;
        state_d = IDLE;
      end
      default: begin
        crc_d   = CRC_INIT;
        count_d = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      crc_q      <= CRC_INIT;
      count_q    <= '0;
      result_q   <= '0;
      bytes_q    <= '0;
      in_reset_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      count_q    <= count_d;
      result_q   <= result_d;
      bytes_q    <= bytes_d;
      in_reset_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ethernet_crc32.sv
// tb/tb_ethernet_crc32.sv - scoreboard bench for ethernet_crc32 (default width and 4-bit count)
// Both instances see the same stream; expected results are queued when a frame is driven.
module tb_ethernet_crc32;

  localparam logic [31:0] POLY = 32'hEDB88320;

  logic        clock;
  logic        reset;
  logic [7:0]  checksum_data;
  logic        checksum_data_valid;
  logic        checksum_data_last;
  logic        en, re, en4, re4;
  logic [31:0] res, res4;
  logic [10:0] cnt;
  logic [3:0]  cnt4;

  typedef struct {
    logic [31:0] crc;
    logic [10:0] cnt;
    logic [3:0]  cnt4;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] frame[$];
  int         compared;
  int         mismatched;
  int         w;
  logic [31:0] last_crc;
  logic [10:0] last_cnt;

  ethernet_crc32 dut (
    .clock                 (clock),
    .reset                 (reset),
    .checksum_data         (checksum_data),
    .checksum_data_valid   (checksum_data_valid),
    .checksum_data_last    (checksum_data_last),
    .checksum_enable       (en),
    .checksum_result       (res),
    .checksum_result_enable(re),
    .checksum_byte_count   (cnt)
  );

  ethernet_crc32 #(.BYTE_COUNT_WIDTH(4)) dut4 (
    .clock                 (clock),
    .reset                 (reset),
    .checksum_data         (checksum_data),
    .checksum_data_valid   (checksum_data_valid),
    .checksum_data_last    (checksum_data_last),
    .checksum_enable       (en4),
    .checksum_result       (res4),
    .checksum_result_enable(re4),
    .checksum_byte_count   (cnt4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bit-serial reference: feedback of CRC LSB against each data bit, LSB first.
  function automatic logic [31:0] crc_model();
    logic [31:0] c;
    logic        fb;
    c = 32'hFFFFFFFF;
    foreach (frame[i]) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ frame[i][b];
        c  = {1'b0, c[31:1]} ^ (fb ? POLY : 32'd0);
      end
    end
    return ~c;
  endfunction

  task automatic push_exp(input logic [31:0] crc);
    exp_t e;
    int   n;
    n      = frame.size();
    e.crc  = crc;
    e.cnt  = (n > 2047) ? 11'h7FF : n[10:0];
    e.cnt4 = (n > 15) ? 4'hF : n[3:0];
    sb.push_back(e);
    last_crc = crc;
    last_cnt = e.cnt;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic l, output int waits);
    waits               = 0;
    checksum_data       = d;
    checksum_data_valid = 1'b1;
    checksum_data_last  = l;
    while (en !== 1'b1 && waits < 20) begin
      @(negedge clock);
      waits++;
    end
    if (waits >= 20) begin
      compared++;
      mismatched++;
      $error("FAIL accept_timeout observed=%0d expected=<20", waits);
    end else begin
      @(negedge clock);
    end
    checksum_data_valid = 1'b0;
    checksum_data_last  = 1'b0;
  endtask

  // Idle gap with a stray last and junk data that must both be ignored.
  task automatic idle(input int n);
    checksum_data_valid = 1'b0;
    checksum_data_last  = 1'b1;
    checksum_data       = 8'hFF;
    repeat (n) @(negedge clock);
    checksum_data_last  = 1'b0;
  endtask

  task automatic send_frame(input int gap, input logic end_last, output int first_waits);
    int wt;
    first_waits = 0;
    for (int i = 0; i < frame.size(); i++) begin
      send_byte(frame[i], end_last && (i == frame.size() - 1), wt);
      if (i == 0) first_waits = wt;
      if (gap > 0 && i < frame.size() - 1) idle(gap);
    end
  endtask

  task automatic load_123456789();
    frame.delete();
    for (int i = 0; i < 9; i++) frame.push_back(8'h31 + i[7:0]);
  endtask

  always @(negedge clock) begin
    if (re === 1'b1 || re4 === 1'b1) begin
      exp_t e;
      chk("strobe_align", {31'd0, re4}, {31'd0, re});
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $error("FAIL unexpected_strobe observed=%h expected=no_strobe", res);
      end else begin
        e = sb.pop_front();
        chk("crc", res, e.crc);
        chk("count", {21'd0, cnt}, {21'd0, e.cnt});
        chk("crc_w4", res4, e.crc);
        chk("count_w4", {28'd0, cnt4}, {28'd0, e.cnt4});
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    compared            = 0;
    mismatched          = 0;
    reset               = 1'b1;
    checksum_data       = 8'h00;
    checksum_data_valid = 1'b0;
    checksum_data_last  = 1'b0;
    repeat (3) @(negedge clock);
    chk("reset_enable", {31'd0, en}, 32'd0);
    chk("reset_strobe", {31'd0, re}, 32'd0);
    chk("reset_result", res, 32'd0);
    chk("reset_count", {21'd0, cnt}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    chk("enable_after_reset", {31'd0, en}, 32'd1);

    // Check value of the standard test string, back to back.
    load_123456789();
    push_exp(32'hCBF43926);
    send_frame(0, 1'b1, w);
    chk("strobe_latency", {31'd0, re}, 32'd1);
    chk("enable_low_in_result", {31'd0, en}, 32'd0);
    @(negedge clock);
    chk("strobe_one_cycle", {31'd0, re}, 32'd0);
    chk("enable_back", {31'd0, en}, 32'd1);

    // Single-byte frame.
    frame.delete();
    frame.push_back(8'h00);
    push_exp(32'hD202EF8D);
    send_frame(0, 1'b1, w);
    chk("single_strobe", {31'd0, re}, 32'd1);
    chk("single_enable_low", {31'd0, en}, 32'd0);
    @(negedge clock);
    chk("single_enable_back", {31'd0, en}, 32'd1);
    idle(2);

    // Gapped frame, then a byte presented during its RESULT cycle.
    load_123456789();
    push_exp(32'hCBF43926);
    send_frame(3, 1'b1, w);
    frame.delete();
    frame.push_back(8'hA5);
    push_exp(crc_model());
    send_frame(0, 1'b1, w);
    chk("held_byte_waits", w, 32'd1);
    idle(3);
    chk("result_hold", res, last_crc);
    chk("count_hold", {21'd0, cnt}, {21'd0, last_cnt});

    // Reset mid-frame, with a last byte presented in the reset cycle.
    frame.delete();
    for (int i = 0; i < 5; i++) frame.push_back(8'h10 + i[7:0]);
    send_frame(0, 1'b0, w);
    reset               = 1'b1;
    checksum_data       = 8'hAA;
    checksum_data_valid = 1'b1;
    checksum_data_last  = 1'b1;
    @(negedge clock);
    chk("midreset_enable", {31'd0, en}, 32'd0);
    reset               = 1'b0;
    checksum_data_valid = 1'b0;
    checksum_data_last  = 1'b0;
    @(negedge clock);
    chk("midreset_strobe", {31'd0, re}, 32'd0);
    chk("midreset_enable_back", {31'd0, en}, 32'd1);
    load_123456789();
    push_exp(32'hCBF43926);
    send_frame(0, 1'b1, w);
    idle(2);

    // 60 data bytes plus their FCS gives the fixed residue.
    frame.delete();
    for (int i = 0; i < 60; i++) frame.push_back(8'($urandom_range(0, 255)));
    begin
      logic [31:0] fcs;
      fcs = crc_model();
      for (int i = 0; i < 4; i++) frame.push_back(fcs[8*i +: 8]);
    end
    push_exp(32'h2144DF1C);
    send_frame(0, 1'b1, w);
    idle(2);

    // 20 random bytes: saturates the 4-bit count instance.
    frame.delete();
    for (int i = 0; i < 20; i++) frame.push_back(8'($urandom_range(0, 255)));
    push_exp(crc_model());
    send_frame(1, 1'b1, w);
    idle(4);

    chk("scoreboard_empty", sb.size(), 32'd0);
    chk("final_result_hold", res, last_crc);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ethernet_crc32.md
ETHERNET_CRC32 -- requirements
Module: ethernet_crc32

Interface
REQ-001 SHALL have parameter BYTE_COUNT_WIDTH, default 11, width of the per-frame byte counter.
REQ-002 SHALL have port clock  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port checksum_data  input  8  frame byte from the packet parser, destination MAC first, FCS excluded.
REQ-005 SHALL have port checksum_data_valid  input  1  byte qualifier.
REQ-006 SHALL have port checksum_data_last  input  1  marks final byte of frame; meaningful only with valid.
REQ-007 SHALL have port checksum_enable  output  1  ready; byte transferred when valid and checksum_enable are both high.
REQ-008 SHALL have port checksum_result  output  32  finished CRC-32; bits [7:0] correspond to first FCS byte on the wire.
REQ-009 SHALL have port checksum_result_enable  output  1  one-cycle strobe qualifying checksum_result.
REQ-010 SHALL have port checksum_byte_count  output  BYTE_COUNT_WIDTH  bytes accepted in the completed frame, qualified by checksum_result_enable.

Function
REQ-011 SHALL compute IEEE 802.3 CRC-32: reflected polynomial 0xEDB88320, LSB-first per byte, initial value 0xFFFFFFFF, final XOR 0xFFFFFFFF.
REQ-012 SHALL process one full byte per accepted transfer (8 bit-steps combinationally), no multi-cycle serialisation.
REQ-013 SHALL implement states IDLE, ACCUMULATE, RESULT.
REQ-014 IDLE: checksum_enable=1, CRC register held at 0xFFFFFFFF, count 0; accepted byte without last -> ACCUMULATE; accepted byte with last -> RESULT.
REQ-015 ACCUMULATE: checksum_enable=1; each accepted byte updates CRC and count; accepted byte with last -> RESULT.
REQ-016 RESULT (exactly one cycle): checksum_enable=0, checksum_result_enable=1, checksum_result = ~CRC, checksum_byte_count = final count; next state IDLE with CRC reinitialised to 0xFFFFFFFF.
REQ-017 Latency: last byte accepted in cycle N -> checksum_result_enable high in cycle N+1 only; checksum_enable high again in cycle N+2.
REQ-018 Bytes presented with checksum_data_valid=1 while checksum_enable=0 SHALL be ignored (not accepted, no state change).
REQ-019 checksum_data_last with checksum_data_valid=0 SHALL be ignored.
REQ-020 checksum_result and checksum_byte_count SHALL hold their last values until the next RESULT cycle.
REQ-021 Byte counter SHALL saturate at 2^BYTE_COUNT_WIDTH-1; CRC continues to update after saturation.
REQ-022 A one-byte frame (valid+last on first byte) SHALL be supported with the same latency as REQ-017.
REQ-023 Idle cycles (valid=0) inside ACCUMULATE SHALL leave CRC and count unchanged, no timeout.
REQ-024 checksum_enable SHALL be driven from registered state only (no combinational path from inputs).

Reset
REQ-025 reset SHALL take priority over all other inputs in the same cycle, including a byte transfer.
REQ-026 On reset: state IDLE, CRC 0xFFFFFFFF, count 0, checksum_enable=0 during reset and 1 in the first cycle after release, checksum_result=0x00000000, checksum_result_enable=0, checksum_byte_count=0.
REQ-027 reset asserted mid-frame SHALL discard the partial frame with no result strobe; next frame computed from initial value.

Verification
REQ-028 ASCII "123456789" (0x31..0x39), last on 0x39, back-to-back -> one strobe one cycle after 0x39, checksum_result=0xCBF43926, count=9.
REQ-029 Single byte 0x00 with last -> next cycle strobe, checksum_result=0xD202EF8D, count=1; checksum_enable low in that cycle only.
REQ-030 "123456789" with valid deasserted for 3 cycles between each byte, and a byte held valid during the RESULT cycle of a preceding frame -> result 0xCBF43926; the held byte is accepted one cycle later, not during RESULT.
REQ-031 64-byte frame (60 data bytes + its correct 4-byte FCS) fed including FCS -> checksum_result=0x2144DF1C (residue), count=64.
REQ-032 reset pulsed after 5 bytes of a frame, then "123456789" -> no strobe for aborted frame; result 0xCBF43926, count=9.
REQ-033 With BYTE_COUNT_WIDTH=4, 20-byte frame -> count=15 (saturated); checksum_result matches software CRC-32 of all 20 bytes.
